// File: rtl/spill_sequencer.sv
// spill_sequencer
//   Turns the raw, asynchronous front-panel spill gate into clean strobes for
//   the cycle counter. The gate is synchronised and debounced, and spills that
//   are too short are rejected. Each accepted spill end produces one `cycle`
//   strobe, after which the block waits for `cnt_ready` or times out. Software
//   counter clears are sequenced so they never coincide with `cycle`.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   gate_in      in   external spill gate (asynchronous to clk)
//   cnt_ready    in   handshake from the cycle counter
//   addr[7:0]    in   register bus address
//   read         in   read strobe (level; the rising edge is the event)
//   write        in   write strobe (level; the rising edge is the event)
//   wdata[7:0]   in   write data
//   cycle        out  one-clock strobe at a valid spill end
//   cnt_reset    out  one-clock clear strobe to the cycle counter
//   spill_active out  high while in SPILL
//   err          out  sticky cnt_ready timeout flag
//   rdata[7:0]   out  registered read data
//
// Register map (offsets from BASE_ADDR)
//   +0  status  {state[1:0], 2'b0, busy, err, spill_active, enable}
//   +1  control write: bit0 enable, bit1 counter clear, bit2 clear err
//               read : {7'b0, enable}
//   +2  len_copy[7:0]   (a read event here snapshots last_len)
//   +3  len_copy[15:8]
module spill_sequencer #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_LEN     = 16,
    parameter int MIN_SPILL   = 64,
    parameter int TIMEOUT     = 8,
    parameter int BASE_ADDR   = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       gate_in,
    input  logic       cnt_ready,
    input  logic [7:0] addr,
    input  logic       read,
    input  logic       write,
    input  logic [7:0] wdata,
    output logic       cycle,
    output logic       cnt_reset,
    output logic       spill_active,
    output logic       err,
    output logic [7:0] rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPILL = 2'd1,
        PULSE = 2'd2,
        WAIT  = 2'd3
    } state_t;

    localparam logic [7:0]  ADDR_STAT = 8'(BASE_ADDR);
    localparam logic [7:0]  ADDR_CTRL = 8'(BASE_ADDR + 1);
    localparam logic [7:0]  ADDR_LENL = 8'(BASE_ADDR + 2);
    localparam logic [7:0]  ADDR_LENH = 8'(BASE_ADDR + 3);
    localparam logic [7:0]  DEB_LAST  = 8'(DEB_LEN - 1);
    localparam logic [15:0] MIN_LEN   = 16'(MIN_SPILL);
    localparam logic [7:0]  TMO       = 8'(TIMEOUT);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   acc;        // accepted (debounced) gate level
    logic [7:0]             deb_cnt;
    logic                   enable;
    logic                   clr_pend;   // counter clear deferred past a cycle strobe
    logic                   write_q;
    logic                   read_q;
    logic [15:0]            length;
    logic [15:0]            last_len;
    logic [15:0]            len_copy;
    logic [7:0]             timer;

    logic        gate_s;
    logic        flip;
    logic        acc_next;
    logic        fall;
    logic        wr_evt;
    logic        rd_evt;
    logic [15:0] len_inc;
    logic [7:0]  timer_inc;
    logic [7:0]  status;
    logic        unused_wdata;

    assign gate_s    = sync[SYNC_STAGES-1];
    // The FSM reacts to the accepted level in the same clock the debouncer flips it.
    assign flip      = (gate_s != acc) && (deb_cnt == DEB_LAST);
    assign acc_next  = flip ? gate_s : acc;
    assign fall      = flip && !gate_s;
    assign wr_evt    = write && !write_q && (addr == ADDR_CTRL);
    assign rd_evt    = read && !read_q && (addr == ADDR_LENL);
    assign len_inc   = sat_inc16(length);
    assign timer_inc = timer + 8'd1;
    assign status    = {state, 2'b00, (state != IDLE), err, spill_active, enable};
    assign unused_wdata = ^wdata[7:3];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            sync         <= '0;
            acc          <= 1'b0;
            deb_cnt      <= 8'd0;
            enable       <= 1'b0;
            clr_pend     <= 1'b0;
            write_q      <= 1'b0;
            read_q       <= 1'b0;
            length       <= 16'd0;
            last_len     <= 16'd0;
            len_copy     <= 16'd0;
            timer        <= 8'd0;
            cycle        <= 1'b0;
            cnt_reset    <= 1'b0;
            spill_active <= 1'b0;
            err          <= 1'b0;
            rdata        <= 8'd0;
        end else begin
            sync    <= {sync[SYNC_STAGES-2:0], gate_in};
            write_q <= write;
            read_q  <= read;

            if (gate_s == acc) begin
                deb_cnt <= 8'd0;
            end else if (flip) begin
                deb_cnt <= 8'd0;
                acc     <= gate_s;
            end else begin
                deb_cnt <= deb_cnt + 8'd1;
            end

            cycle     <= 1'b0;
            cnt_reset <= clr_pend;
            clr_pend  <= 1'b0;

            if (wr_evt) begin
                enable <= wdata[0];
                // cycle goes high on the clock after PULSE, so a clear requested
                // while in PULSE slips one clock to stay clear of it.
                if (wdata[1]) begin
                    if (state == PULSE) clr_pend  <= 1'b1;
                    else                cnt_reset <= 1'b1;
                end
                if (wdata[2]) err <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (acc_next && enable) begin
                        state        <= SPILL;
                        length       <= 16'd0;
                        spill_active <= 1'b1;
                    end
                end
                SPILL: begin
                    length <= len_inc;
                    if (!enable) begin
                        state        <= IDLE;
                        spill_active <= 1'b0;
                    end else if (fall) begin
                        spill_active <= 1'b0;
                        if (len_inc >= MIN_LEN) begin
                            last_len <= len_inc;
                            state    <= PULSE;
                        end else begin
                            state    <= IDLE;
                        end
                    end
                end
                PULSE: begin
                    cycle <= 1'b1;
                    timer <= 8'd0;
                    state <= WAIT;
                end
                WAIT: begin
                    if (cnt_ready) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer_inc;
                        // Assigned after the software clear so a timeout wins.
                        if (timer_inc == TMO) begin
                            err   <= 1'b1;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase

            if (rd_evt) len_copy <= last_len;

            case (addr)
                ADDR_STAT: rdata <= status;
                ADDR_CTRL: rdata <= {7'd0, enable};
                ADDR_LENL: rdata <= len_copy[7:0];
                ADDR_LENH: rdata <= len_copy[15:8];
                default:   rdata <= rdata;
            endcase
        end
    end

endmodule

// File: tb/tb_spill_sequencer.sv
// Testbench for spill_sequencer: directed stimulus with a scoreboard. Stimulus
// pushes the expected clock index of each DUT strobe/edge and the expected value
// of each register read; a monitor on the falling clock edge pops and compares
// whenever the DUT presents one of those outputs.
module tb_spill_sequencer;

    localparam int LAT = 2 + 4;   // synchroniser depth + debounce length

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       gate_in = 1'b0;
    logic       cnt_ready = 1'b0;
    logic [7:0] addr = 8'd0;
    logic       read = 1'b0;
    logic       write = 1'b0;
    logic [7:0] wdata = 8'd0;
    logic       cycle;
    logic       cnt_reset;
    logic       spill_active;
    logic       err;
    logic [7:0] rdata;

    logic  ready_en = 1'b1;
    logic  rd_req = 1'b0;
    logic  rd_vld = 1'b0;
    logic  spill_q = 1'b0;
    logic  err_q = 1'b0;
    int    cyc = 0;
    int    checks = 0;
    int    passes = 0;

    int    exp_spill[$];
    int    exp_cyc[$];
    int    exp_crst[$];
    int    exp_err[$];
    int    rd_exp[$];
    string rd_name[$];

    spill_sequencer #(
        .SYNC_STAGES(2), .DEB_LEN(4), .MIN_SPILL(8), .TIMEOUT(8), .BASE_ADDR(14)
    ) dut (
        .clk(clk), .reset(reset), .gate_in(gate_in), .cnt_ready(cnt_ready),
        .addr(addr), .read(read), .write(write), .wdata(wdata),
        .cycle(cycle), .cnt_reset(cnt_reset), .spill_active(spill_active),
        .err(err), .rdata(rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc       <= cyc + 1;
        rd_vld    <= rd_req;
        cnt_ready <= cycle & ready_en;   // counter answers one clock after cycle
    end

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, required %0d", name, act, exp);
    endfunction

    function automatic void unexpected(input string name);
        checks++;
        $display("FAIL %s: unexpected at clk %0d, none required", name, cyc);
    endfunction

    // Monitor
    always @(negedge clk) begin
        if (cycle) begin
            if (exp_cyc.size() == 0) unexpected("cycle_pulse");
            else chk("cycle_time", cyc, exp_cyc.pop_front());
        end
        if (cnt_reset) begin
            if (exp_crst.size() == 0) unexpected("cnt_reset_pulse");
            else chk("cnt_reset_time", cyc, exp_crst.pop_front());
        end
        if (spill_active && !spill_q) begin
            if (exp_spill.size() == 0) unexpected("spill_rise");
            else chk("spill_rise_time", cyc, exp_spill.pop_front());
        end
        if (err && !err_q) begin
            if (exp_err.size() == 0) unexpected("err_rise");
            else chk("err_rise_time", cyc, exp_err.pop_front());
        end
        if (rd_vld) begin
            if (rd_exp.size() == 0) unexpected("rdata_valid");
            else chk(rd_name.pop_front(), int'(rdata), rd_exp.pop_front());
        end
        spill_q = spill_active;
        err_q   = err;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr = a; wdata = d; write = 1'b1;
        tick();
        write = 1'b0;
        tick();
    endtask

    task automatic read_evt();
        addr = 8'd16; read = 1'b1;
        tick();
        read = 1'b0;
        tick();
    endtask

    task automatic read_reg(input logic [7:0] a, input int exp, input string name);
        addr = a; rd_req = 1'b1;
        rd_exp.push_back(exp);
        rd_name.push_back(name);
        tick();
        rd_req = 1'b0;
    endtask

    // Gate high for `hi` clocks starting now; leaves cyc at the falling time.
    task automatic gate_pulse(input int hi, input bit exp_sp, input bit exp_cy);
        gate_in = 1'b1;
        if (exp_sp) exp_spill.push_back(cyc + LAT);
        repeat (hi) tick();
        gate_in = 1'b0;
        if (exp_cy) exp_cyc.push_back(cyc + LAT + 1);
    endtask

    initial begin
        // Reset state
        repeat (3) tick();
        chk("reset_cycle", int'(cycle), 0);
        chk("reset_cnt_reset", int'(cnt_reset), 0);
        chk("reset_spill_active", int'(spill_active), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_rdata", int'(rdata), 0);
        reset = 1'b0;
        tick();
        read_reg(8'd14, 8'h00, "status_after_reset");
        read_reg(8'd15, 8'h00, "enable_after_reset");
        wr(8'd15, 8'h01);
        read_reg(8'd15, 8'h01, "enable_written");

        // 1: valid 100-clock spill
        gate_pulse(100, 1'b1, 1'b1);
        repeat (20) tick();
        read_evt();
        read_reg(8'd16, 100, "len_lo_spill1");
        read_reg(8'd17, 0, "len_hi_spill1");
        read_reg(8'd14, 8'h01, "status_idle_spill1");

        // 2: runt spill of 6 clocks
        gate_pulse(6, 1'b1, 1'b0);
        repeat (20) tick();
        read_reg(8'd14, 8'h01, "status_after_runt");
        read_evt();
        read_reg(8'd16, 100, "len_kept_after_runt");

        // 3: chatter shorter than the debounce window
        for (int i = 0; i < 12; i++) begin
            gate_in = 1'b1;
            repeat (2) tick();
            gate_in = 1'b0;
            repeat (2) tick();
        end
        repeat (10) tick();
        read_reg(8'd14, 8'h01, "status_after_chatter");

        // 4: counter never answers -> timeout 8 clocks after cycle
        ready_en = 1'b0;
        gate_pulse(20, 1'b1, 1'b1);
        exp_err.push_back(cyc + LAT + 1 + 8);
        repeat (25) tick();
        read_reg(8'd14, 8'h05, "status_err_set");
        read_evt();
        read_reg(8'd16, 20, "len_lo_spill4");
        wr(8'd15, 8'h05);
        read_reg(8'd14, 8'h01, "status_err_cleared");
        read_reg(8'd15, 8'h01, "enable_kept_after_clear");
        ready_en = 1'b1;

        // Counter clear from IDLE lands on the next clock
        exp_crst.push_back(cyc + 1);
        wr(8'd15, 8'h03);
        repeat (5) tick();

        // 5: counter clear landing in PULSE is deferred past cycle
        gate_pulse(20, 1'b1, 1'b1);
        exp_crst.push_back(cyc + LAT + 2);
        repeat (LAT) tick();
        wr(8'd15, 8'h03);
        repeat (15) tick();
        read_reg(8'd15, 8'h01, "enable_after_clear");

        // 6: asynchronous reset in the middle of a spill
        read_reg(8'd14, 8'h01, "status_before_reset");
        gate_in = 1'b1;
        exp_spill.push_back(cyc + LAT);
        repeat (10) tick();
        read_reg(8'd14, 8'h4B, "status_in_spill");
        repeat (10) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_spill_active", int'(spill_active), 0);
        chk("async_cycle", int'(cycle), 0);
        chk("async_err", int'(err), 0);
        chk("async_rdata", int'(rdata), 0);
        tick();
        tick();
        reset = 1'b0;
        gate_in = 1'b0;
        repeat (10) tick();
        read_reg(8'd15, 8'h00, "enable_cleared_by_reset");
        gate_in = 1'b1;
        repeat (10) tick();
        read_reg(8'd14, 8'h00, "no_spill_while_disabled");
        repeat (10) tick();
        gate_in = 1'b0;
        repeat (10) tick();
        wr(8'd15, 8'h01);
        gate_pulse(20, 1'b1, 1'b1);
        repeat (20) tick();

        // Anything still expected never appeared
        while (exp_spill.size() > 0) begin
            checks++; $display("FAIL spill_rise: missing, required at clk %0d", exp_spill.pop_front());
        end
        while (exp_cyc.size() > 0) begin
            checks++; $display("FAIL cycle_pulse: missing, required at clk %0d", exp_cyc.pop_front());
        end
        while (exp_crst.size() > 0) begin
            checks++; $display("FAIL cnt_reset_pulse: missing, required at clk %0d", exp_crst.pop_front());
        end
        while (exp_err.size() > 0) begin
            checks++; $display("FAIL err_rise: missing, required at clk %0d", exp_err.pop_front());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
